// File: rtl/keypad_scan_encoder.sv
// Matrix keypad scanner: synchronizes row senses, debounces a press, scans the columns
// one-hot and reports the lowest pressed key index with a multi-key flag under a valid/ack handshake.
module keypad_scan_encoder #(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES   = 3,
    localparam int unsigned CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   col_o,
    output logic [CODE_W-1:0] code_o,
    output logic              multi_o,
    output logic              valid_o,
    input  logic              ack_i
);

    localparam int unsigned ColIdxW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DebW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SetW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [DebW-1:0]    DebLast = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SetW-1:0]    SetLast = SetW'(SETTLE_CYCLES - 1);
    localparam logic [ColIdxW-1:0] ColLast = ColIdxW'(COLS - 1);
    localparam logic [COLS-1:0]    ColOne  = COLS'(1);

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StScan,
        StReport,
        StRelease
    } state_e;

    state_e              state_q;
    logic [ROWS-1:0]     row_meta_q;
    logic [ROWS-1:0]     row_s_q;
    logic [DebW-1:0]     cnt_q;
    logic [SetW-1:0]     settle_q;
    logic [ColIdxW-1:0]  col_idx_q;
    logic [COLS-1:0]     col_q;
    logic [CODE_W-1:0]   code_q;
    logic                multi_q;
    logic                valid_q;
    logic [CODE_W-1:0]   best_q;
    logic [1:0]          hits_q;

    logic [CODE_W-1:0]   col_best;
    logic [1:0]          col_hits;
    logic [2:0]          hit_sum;
    logic [1:0]          tot_hits;
    logic [CODE_W-1:0]   new_best;

    assign col_o   = col_q;
    assign code_o  = code_q;
    assign multi_o = multi_q;
    assign valid_o = valid_q;

    // Hits in the column being sampled; descending loop leaves the lowest row in col_best.
    always_comb begin
        col_best = '0;
        col_hits = 2'd0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (row_s_q[r]) begin
                col_best = CODE_W'(r * int'(COLS) + int'(col_idx_q));
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
            end
        end
        hit_sum  = {1'b0, hits_q} + {1'b0, col_hits};
        tot_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        new_best = best_q;
        if (col_hits != 2'd0 && (hits_q == 2'd0 || col_best < best_q)) begin
            new_best = col_best;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            row_meta_q <= '0;
            row_s_q    <= '0;
            cnt_q      <= '0;
            settle_q   <= '0;
            col_idx_q  <= '0;
            col_q      <= '1;
            code_q     <= '0;
            multi_q    <= 1'b0;
            valid_q    <= 1'b0;
            best_q     <= '0;
            hits_q     <= 2'd0;
        end else begin
            row_meta_q <= row_i;
            row_s_q    <= row_meta_q;
            unique case (state_q)
                StIdle: begin
                    col_q <= '1;
                    if (|row_s_q) begin
                        state_q <= StDebounce;
                        cnt_q   <= '0;
                    end
                end
                StDebounce: begin
                    if (row_s_q == '0) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == DebLast) begin
                        state_q   <= StScan;
                        cnt_q     <= '0;
                        col_idx_q <= '0;
                        settle_q  <= '0;
                        col_q     <= ColOne;
                        hits_q    <= 2'd0;
                        best_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StScan: begin
                    if (settle_q == SetLast) begin
                        settle_q <= '0;
                        hits_q   <= tot_hits;
                        best_q   <= new_best;
                        if (col_idx_q == ColLast) begin
                            col_q <= '1;
                            if (tot_hits != 2'd0) begin
                                state_q <= StReport;
                                code_q  <= new_best;
                                multi_q <= (tot_hits == 2'd2);
                                valid_q <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            col_idx_q <= col_idx_q + 1'b1;
                            col_q     <= ColOne << (col_idx_q + 1'b1);
                        end
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StReport: begin
                    col_q <= '1;
                    if (ack_i) begin
                        valid_q <= 1'b0;
                        state_q <= StRelease;
                        cnt_q   <= '0;
                    end
                end
                StRelease: begin
                    col_q <= '1;
                    if (|row_s_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DebLast) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    col_q   <= '1;
                end
            endcase
        end
    end

endmodule

// File: doc/keypad_scan_encoder.md
KEYPAD_SCAN_ENCODER -- requirements
Module: keypad_scan_encoder

Interface
REQ-001 Parameter ROWS, default 4: number of keypad rows sensed.
REQ-002 Parameter COLS, default 4: number of keypad columns driven.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a press or a release.
REQ-004 Parameter SETTLE_CYCLES, default 3, minimum 3: clock cycles each column is driven during a scan.
REQ-005 Derived CODE_W = clog2(ROWS*COLS), minimum 1.
REQ-006 clock  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 Row  input  ROWS  raw row sense lines, active-high, asynchronous to clock.
REQ-009 Col  output  COLS  column drive lines, active-high, registered.
REQ-010 Code  output  CODE_W  encoded key index = row*COLS + col.
REQ-011 Multi  output  1  more than one key was detected in the reported scan.
REQ-012 Valid  output  1  Code/Multi hold a new key event.
REQ-013 Ack  input  1  consumer accepts the event.

Function
REQ-014 Row SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (RowS).
REQ-015 FSM states SHALL be IDLE, DEBOUNCE, SCAN, REPORT, RELEASE.
REQ-016 IDLE: Col SHALL be all ones; any RowS bit high SHALL move to DEBOUNCE with the counter cleared.
REQ-017 DEBOUNCE: Col all ones; counter SHALL increment each cycle RowS is nonzero; RowS zero SHALL return to IDLE; the counter reaching DEBOUNCE_CYCLES SHALL move to SCAN at column 0.
REQ-018 SCAN: Col SHALL be one-hot at column c for exactly SETTLE_CYCLES cycles, c = 0..COLS-1 in ascending order; RowS SHALL be sampled in the last cycle of each column.
REQ-019 Key (r,c) SHALL be detected when RowS[r] is high in the sample cycle of column c.
REQ-020 Code SHALL capture the lowest detected index; Multi SHALL be set if two or more keys are detected across the whole scan.
REQ-021 At scan end with at least one key detected, the FSM SHALL enter REPORT; with none detected (bounce), it SHALL enter IDLE with Valid never asserted.
REQ-022 REPORT: Valid SHALL be high; Code and Multi SHALL be stable while Valid is high; Col SHALL be all ones.
REQ-023 Ack high while Valid is high SHALL deassert Valid on the next edge and enter RELEASE; Ack while Valid is low SHALL be ignored.
REQ-024 A key released while in REPORT SHALL NOT cancel the event; Valid SHALL hold until Ack.
REQ-025 RELEASE: Col all ones; counter SHALL increment each cycle RowS is zero and clear when RowS is nonzero; reaching DEBOUNCE_CYCLES SHALL return to IDLE; a held key SHALL produce no repeat event.
REQ-026 Code and Multi SHALL retain their last values outside REPORT.
REQ-027 Counters SHALL saturate or clear at the terminal count and SHALL NOT wrap.

Reset
REQ-028 Reset assertion SHALL immediately force state IDLE, Col all ones, Code 0, Multi 0, Valid 0, counters 0, and synchronizer 0, including mid-scan or mid-REPORT.
REQ-029 After reset deassertion, a key already held SHALL be treated as a new press and pass through DEBOUNCE.

Verification (defaults ROWS=4, COLS=4, DEBOUNCE=4, SETTLE=3)
REQ-030 Key (2,1) pressed and held, model returns Row[2] only when Col[1] or all columns are driven -> Valid within 2+4+12+2 cycles, Code=9, Multi=0; Ack -> Valid low next cycle; no second event while held; release for 4+ cycles -> IDLE.
REQ-031 Keys (0,3) and (1,0) held -> Code=3, Multi=1.
REQ-032 Row pulse of 2 cycles -> return to IDLE, Valid never asserted; pulse of 6 cycles released before scan -> no event.
REQ-033 Valid held 20 cycles without Ack while the key is released -> Code stable and Valid high throughout; Ack -> RELEASE -> IDLE.
REQ-034 Reset asserted during SCAN column 2 -> Col=4'b1111, Valid=0 asynchronously; held key re-debounced after release of reset.
REQ-035 Reparameterized ROWS=2, COLS=3, key (1,2) -> Code=5 (CODE_W=3).
